// File: rtl/decoder_scan_ctrl.sv
// Scan controller for a 2x4 decoder: walks the select lines {A,B} through
// 00->01->10->11, opening a timed enable window per slot behind a blanking guard.
module decoder_scan_ctrl #(
  parameter int ACTIVE_CYCLES = 1000,
  parameter int BLANK_CYCLES  = 2,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  input  logic clr,
  output logic A,
  output logic B,
  output logic E,
  output logic slot_done,
  output logic frame_done,
  output logic busy
);

  // Handshake: none. run is a level, step is a single-cycle request honoured
  // only from IDLE with run low, clr is a synchronous abort with top priority.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACTIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       slot_q, slot_d;
  logic             e_q, e_d;
  logic             slot_done_q, slot_done_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      slot_q       <= 2'b00;
      e_q          <= 1'b0;
      slot_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      slot_q       <= slot_d;
      e_q          <= e_d;
      slot_done_q  <= slot_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    slot_d  = slot_q;
    if (clr) begin
      state_d = ST_IDLE;
      timer_d = '0;
      slot_d  = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run || step) begin
            state_d = ST_BLANK;
            timer_d = '0;
          end
        end
        ST_BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = ST_ACTIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        ST_ACTIVE: begin
          // The slot advances on the same edge that drops E, so the select
          // lines only ever move while the decoder is disabled.
          if (timer_q == ACT_LAST) begin
            slot_d  = slot_q + 2'd1;
            timer_d = '0;
            state_d = run ? ST_BLANK : ST_IDLE;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next-state values so they land in flops
  // aligned with the state they describe.
  always_comb begin
    e_d          = (state_d == ST_ACTIVE);
    slot_done_d  = e_d && (timer_d == ACT_LAST);
    frame_done_d = slot_done_d && (slot_d == 2'b11);
    busy_d       = (state_d != ST_IDLE);
  end

  assign A          = slot_q[1];
  assign B          = slot_q[0];
  assign E          = e_q;
  assign slot_done  = slot_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: directed scenarios plus random run/step/clr
// traffic, checked every cycle against a slot-position reference model.
module tb_decoder_scan_ctrl;

  localparam int ACT = 4;
  localparam int BLK = 2;
  localparam int PER = ACT + BLK;

  logic clk;
  logic rst_n;
  logic run, step, clr;
  logic A, B, E, slot_done, frame_done, busy;

  int n_vec;
  int n_err;

  // Reference model: position within the current slot period plus slot index.
  bit m_busy;
  int m_pos;
  int m_slot;

  bit         prev_e;
  logic [1:0] prev_ab;

  decoder_scan_ctrl #(
    .ACTIVE_CYCLES(ACT),
    .BLANK_CYCLES (BLK),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .clr       (clr),
    .A         (A),
    .B         (B),
    .E         (E),
    .slot_done (slot_done),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_pos  = 0;
    m_slot = 0;
  endtask

  task automatic model_step();
    if (!rst_n) model_reset();
    else if (clr) model_reset();
    else if (!m_busy) begin
      if (run || step) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end else if (m_pos == PER - 1) begin
      m_slot = (m_slot + 1) % 4;
      m_pos  = 0;
      m_busy = run;
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_outputs();
    bit exp_e, exp_sd;
    exp_e  = m_busy && (m_pos >= BLK);
    exp_sd = m_busy && (m_pos == PER - 1);
    chk("E", E, exp_e);
    chk("AB", {A, B}, m_slot[1:0]);
    chk("busy", busy, m_busy);
    chk("slot_done", slot_done, exp_sd);
    chk("frame_done", frame_done, exp_sd && (m_slot == 3));
    if (prev_e && E) chk("ab_stable", {A, B}, prev_ab);
    prev_e  = E;
    prev_ab = {A, B};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic step_pulse();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  initial begin
    int guard;
    n_vec  = 0;
    n_err  = 0;
    prev_e = 1'b0;
    prev_ab = 2'b00;
    run = 1'b0; step = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();

    // T1: reset state, then async reset while E is high
    cycles(3);
    #2 rst_n = 1'b1;
    cycles(2);
    run = 1'b1;
    guard = 0;
    while (!(m_busy && m_pos >= BLK + 1) && guard < 40) begin
      cycle();
      guard++;
    end
    chk("t1_reach_active", guard < 40, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_E", E, 1'b0);
    chk("t1_async_AB", {A, B}, 2'b00);
    chk("t1_async_busy", busy, 1'b0);
    model_reset();
    prev_e = 1'b0;
    run = 1'b0;
    cycles(2);
    #3 rst_n = 1'b1;
    cycles(5);
    chk("t1_idle_busy", busy, 1'b0);

    // T2: free run over several frames
    run = 1'b1;
    cycles(4 * PER * 3 + 3);
    run = 1'b0;
    cycles(PER + 2);

    // T3: single-step walk from slot 00, with extra steps while busy
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_pulse();
      cycles(3);
      step_pulse();
      cycles(15);
    end
    chk("t3_idle_AB", {A, B}, 2'b00);
    chk("t3_idle_busy", busy, 1'b0);

    // T4: drop run on the second active cycle of slot 01
    run = 1'b1;
    guard = 0;
    while (!(m_busy && m_slot == 1 && m_pos == BLK + 1) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("t4_reach", guard < 100, 1'b1);
    run = 1'b0;
    cycles(10);
    chk("t4_AB", {A, B}, 2'b10);
    chk("t4_busy", busy, 1'b0);

    // T5: clr together with step during the active window of slot 10
    run = 1'b1;
    guard = 0;
    while (!(m_busy && m_slot == 2 && m_pos == BLK + 1) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("t5_reach", guard < 100, 1'b1);
    run = 1'b0;
    clr = 1'b1;
    step = 1'b1;
    cycle();
    clr = 1'b0;
    step = 1'b0;
    chk("t5_E", E, 1'b0);
    chk("t5_AB", {A, B}, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_slot_done", slot_done, 1'b0);
    cycles(4);

    // Random run/step/clr traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = ($urandom_range(0, 9) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      cycle();
    end
    run = 1'b0; step = 1'b0; clr = 1'b0;
    cycles(PER + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
